// File: rtl/uart_stream_tx.sv
// uart_stream_tx
// Accepts bytes over a valid/ready handshake into a small FIFO and sends each
// one as an 8N1 UART frame on a single pin: a start bit (low), eight data bits
// LSB first, then a stop bit (high). Each bit lasts CLKS_PER_BIT clock cycles.
// Frames run back to back while the FIFO holds data, with no idle gap.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    bytes buffered (power of two, >= 2)
//   LW            width of level (derived; leave at its default)
//
// Ports
//   clk       in   clock; all state updates on the rising edge
//   rst_n     in   asynchronous active-low reset
//   in_data   in   byte offered by the upstream stage
//   in_valid  in   in_data is valid this cycle
//   in_ready  out  the FIFO can accept a byte this cycle
//   tx        out  serial line; idles high
//   busy      out  a frame is in flight or the FIFO is non-empty
//   level     out  number of bytes currently held in the FIFO

module uart_stream_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned LW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          tx,
  output logic          busy,
  output logic [LW-1:0] level
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [TW-1:0] TimerMax  = TW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LevelFull = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  // Serializer state
  state_e        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shreg;
  logic          r_tx;

  logic       w_push;
  logic       w_pop;
  logic       w_bit_done;
  logic [7:0] w_head;

  // in_ready depends only on registered level, so a pop in the same cycle
  // cannot open a slot until the following cycle.
  assign in_ready   = (r_level != LevelFull);
  assign w_push     = in_valid && in_ready;
  assign w_bit_done = (r_timer == TimerMax);
  assign w_head     = r_mem[r_rd_ptr];

  // A pop happens when idle with data, or at the end of a stop bit with data
  // waiting; the latter chains frames without an idle cycle.
  assign w_pop = (r_level != '0) &&
                 ((r_state == StIdle) || ((r_state == StStop) && w_bit_done));

  //--------------------------------------------------------------------------
  // FIFO: pointers wrap naturally at PW bits; level is tracked on its own so
  // full and empty are unambiguous.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Serializer FSM. tx is registered so the pin never glitches; the bit timer
  // restarts on every state or bit change.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_tx      <= 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_timer <= '0;
          r_tx    <= 1'b1;
          if (w_pop) begin
            r_shreg <= w_head;
            r_state <= StStart;
            r_tx    <= 1'b0;
          end
        end

        StStart: begin
          if (w_bit_done) begin
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_state   <= StData;
            r_tx      <= r_shreg[0];
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        StData: begin
          if (w_bit_done) begin
            r_timer <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= StStop;
              r_tx    <= 1'b1;
            end else begin
              // Next bit is shreg[1] before the shift lands.
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shreg   <= {1'b0, r_shreg[7:1]};
              r_tx      <= r_shreg[1];
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        StStop: begin
          if (w_bit_done) begin
            r_timer <= '0;
            if (w_pop) begin
              r_shreg <= w_head;
              r_state <= StStart;
              r_tx    <= 1'b0;
            end else begin
              r_state <= StIdle;
              r_tx    <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        default: begin
          r_state <= StIdle;
          r_timer <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx    = r_tx;
  assign busy  = (r_state != StIdle) || (r_level != '0);
  assign level = r_level;

endmodule

// File: tb/tb_uart_stream_tx.sv
// Testbench for uart_stream_tx with CLKS_PER_BIT = 4, FIFO_DEPTH = 4.
// Accepted bytes go into a scoreboard queue; a serial decoder pops and compares
// each frame it receives. Directed steps check timing and boundary behaviour.

module tb_uart_stream_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 3;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic [7:0]    in_data  = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          tx;
  logic          busy;
  logic [LW-1:0] level;

  always #5 clk = ~clk;

  uart_stream_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy),
    .level    (level)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int frames   = 0;

  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  // Scoreboard push: record every accepted byte.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  // Serial decoder, sampling at negedges. cnt counts negedges since the first
  // low sample of the start bit.
  initial begin
    logic       active;
    int         cnt;
    logic [7:0] dbyte;
    logic [7:0] eb;
    active = 1'b0;
    cnt    = 0;
    dbyte  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx == 1'b0) begin
          active = 1'b1;
          cnt    = 0;
        end
      end else begin
        cnt++;
        if (cnt == 2) check("start_bit", 32'(tx), 32'd0);
        if (cnt >= 5 && cnt <= 33 && ((cnt - 5) % 4) == 0) dbyte[(cnt - 5) / 4] = tx;
        if (cnt == 37) begin
          check("stop_bit", 32'(tx), 32'd1);
          check("frame_pending", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            eb = exp_q.pop_front();
            check("frame_byte", 32'(dbyte), 32'(eb));
          end
          frames++;
          active = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ok;
    logic       acc;
    logic [7:0] b;
    logic [7:0] d;
    logic [LW-1:0] maxlvl;
    logic       exp_tx;
    int         acc5;
    int         f0;
    int         k;
    int         n;

    // 1. Reset values
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
    end
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!(tx === 1'b1 && busy === 1'b0 && level === '0 && in_ready === 1'b1)) ok = 1'b0;
    end
    check("idle_50_cycles", 32'(ok), 32'd1);

    // 2. Single byte 0xA5
    b        = 8'hA5;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("push_latency_level", 32'(level), 32'd1);
    for (int e = 1; e <= 44; e++) begin
      @(negedge clk);
      if (e <= 4) exp_tx = 1'b0;
      else if (e <= 36) exp_tx = b[(e - 5) / 4];
      else exp_tx = 1'b1;
      check($sformatf("a5_tx_e%0d", e), 32'(tx), 32'(exp_tx));
      if (e == 40) check("a5_busy_e40", 32'(busy), 32'd1);
      if (e == 41) check("a5_busy_e41", 32'(busy), 32'd0);
    end
    wait_idle(100);

    // 3. Fill to full: 0x00..0x05 offered from edge 0
    f0       = frames;
    d        = 8'h00;
    acc5     = -1;
    in_data  = d;
    in_valid = 1'b1;
    for (int e = 0; e <= 241; e++) begin
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) begin
        if (d == 8'h05) acc5 = e;
        d = d + 8'h01;
        if (d <= 8'h05) in_data = d;
        else in_valid = 1'b0;
      end
      if (e == 1) begin
        check("fill_tx_low_e1", 32'(tx), 32'd0);
        check("fill_level_e1", 32'(level), 32'd1);
      end
      if (e == 3) check("fill_ready_e3", 32'(in_ready), 32'd1);
      if (e == 4) begin
        check("fill_level_e4", 32'(level), 32'd4);
        check("fill_ready_e4", 32'(in_ready), 32'd0);
      end
      if (e == 40) check("fill_ready_e40", 32'(in_ready), 32'd0);
      if (e == 41) begin
        check("fill_level_e41", 32'(level), 32'd3);
        check("fill_ready_e41", 32'(in_ready), 32'd1);
      end
      if (e == 240) check("fill_busy_e240", 32'(busy), 32'd1);
      if (e == 241) begin
        check("fill_busy_e241", 32'(busy), 32'd0);
        check("fill_tx_e241", 32'(tx), 32'd1);
      end
    end
    check("fill_accept_edge_05", 32'(acc5), 32'd42);
    check("fill_frames", 32'(frames - f0), 32'd6);
    check("fill_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4. Push on the STOP->START pop edge with level = 2
    repeat (3) @(negedge clk);
    f0 = frames;
    for (int e = 0; e <= 41; e++) begin
      in_valid = 1'b1;
      case (e)
        0:       in_data = 8'h11;
        1:       in_data = 8'h22;
        2:       in_data = 8'h33;
        41:      in_data = 8'h44;
        default: in_valid = 1'b0;
      endcase
      @(negedge clk);
      in_valid = 1'b0;
      if (e == 2) check("coinc_level_e2", 32'(level), 32'd2);
      if (e == 40) check("coinc_level_e40", 32'(level), 32'd2);
      if (e == 41) begin
        check("coinc_level_e41", 32'(level), 32'd2);
        check("coinc_tx_start_e41", 32'(tx), 32'd0);
      end
    end
    wait_idle(400);
    check("coinc_frames", 32'(frames - f0), 32'd4);
    check("coinc_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5. Reset during data bit 3 of 0x5A with two bytes queued
    repeat (3) @(negedge clk);
    for (int e = 0; e <= 18; e++) begin
      in_valid = 1'b1;
      case (e)
        0:       in_data = 8'h5A;
        1:       in_data = 8'h77;
        2:       in_data = 8'h88;
        default: in_valid = 1'b0;
      endcase
      @(negedge clk);
      in_valid = 1'b0;
      if (e == 2) check("mid_level_e2", 32'(level), 32'd2);
      if (e == 14) check("mid_bit2_low", 32'(tx), 32'd0);
    end
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_tx_async", 32'(tx), 32'd1);
    check("mid_rst_level_async", 32'(level), 32'd0);
    check("mid_rst_busy_async", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_tx_held", 32'(tx), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_post_level", 32'(level), 32'd0);
    check("mid_post_ready", 32'(in_ready), 32'd1);
    f0       = frames;
    in_data  = 8'h3C;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle(100);
    check("mid_new_frames", 32'(frames - f0), 32'd1);
    check("mid_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6. Stream 0x10..0x23 with random valid gaps
    f0     = frames;
    k      = 0;
    n      = 0;
    maxlvl = '0;
    while (k < 20 && n < 4000) begin
      if (!in_valid) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'h10 + 8'(k);
      end
      acc = in_valid && in_ready;
      @(negedge clk);
      n++;
      if (level > maxlvl) maxlvl = level;
      if (acc) begin
        k++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("wrap_all_pushed", 32'(k), 32'd20);
    wait_idle(400);
    check("wrap_frames", 32'(frames - f0), 32'd20);
    check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
    check("wrap_level_max_ok", 32'(maxlvl <= 3'd4), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
